// File: rtl/bpi_flash_reader.sv
// Asynchronous 16-bit BPI NOR flash burst reader feeding the power-up reconfiguration path.
// Optional HOLD auto-close is enabled by defining READ_TIMEOUT_EN.
module bpi_flash_reader #(
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                BURST_LEN  = 8,
    parameter int                T_ACC      = 6,
    parameter int                T_HIZ      = 2,
    parameter int                TIMEOUT    = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reconfig_read_start,
    input  logic              reconfig_read_continue,
    input  logic              reconfig_read_end,
    input  logic [15:0]       bpi_data_in,
    output logic [15:0]       reconfig_data,
    output logic              reconfig_data_en,
    output logic              bpi_idle,
    output logic [ADDR_W-1:0] bpi_addr,
    output logic              bpi_ce_n,
    output logic              bpi_oe_n,
    output logic              bpi_we_n,
    output logic              bpi_adv_n,
    output logic              read_timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_HOLD, S_RECOVER
    } state_t;

    localparam logic [5:0] TACC_LAST = 6'(T_ACC - 1);
    localparam logic [5:0] THIZ_LAST = 6'(T_HIZ - 1);
    localparam logic [7:0] BLEN      = 8'(BURST_LEN);

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [7:0]        burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              en_q, en_d;
    logic              cs_n_q, cs_n_d;
    logic              idle_q, idle_d;
    logic              tmo_q, tmo_d;

`ifdef READ_TIMEOUT_EN
    localparam int            DW  = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] TMO = DW'(TIMEOUT);
    logic [DW-1:0] dwell_q, dwell_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = 1'b0;
        tmo_d   = 1'b0;
`ifdef READ_TIMEOUT_EN
        dwell_d = dwell_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (reconfig_read_start) begin
                    state_d = S_SETUP;
                    addr_d  = START_ADDR;
                    burst_d = '0;
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = reconfig_read_end ? S_RECOVER : S_WAIT;
            end
            S_WAIT: begin
                if (reconfig_read_end) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                end else if (cnt_q == TACC_LAST) begin
                    // sample on the last wait cycle so the strobe lands in CAPTURE
                    state_d = S_CAPTURE;
                    data_d  = bpi_data_in;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_CAPTURE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (reconfig_read_end) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                end else if (burst_q + 8'd1 == BLEN) begin
                    state_d = S_HOLD;
                    burst_d = '0;
`ifdef READ_TIMEOUT_EN
                    dwell_d = '0;
`endif
                end else begin
                    state_d = S_SETUP;
                    burst_d = burst_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (reconfig_read_end) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                end else if (reconfig_read_continue) begin
                    state_d = S_SETUP;
`ifdef READ_TIMEOUT_EN
                end else if (dwell_q + DW'(1) == TMO) begin
                    state_d = S_RECOVER;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    dwell_d = dwell_q + DW'(1);
`endif
                end
            end
            S_RECOVER: begin
                if (cnt_q == THIZ_LAST) begin
                    state_d = S_IDLE;
                    addr_d  = START_ADDR;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // bus strobes and idle follow the state being entered so they are registered
        cs_n_d = !(state_d == S_SETUP || state_d == S_WAIT || state_d == S_CAPTURE);
        idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            burst_q <= '0;
            addr_q  <= START_ADDR;
            data_q  <= '0;
            en_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            idle_q  <= 1'b1;
            tmo_q   <= 1'b0;
`ifdef READ_TIMEOUT_EN
            dwell_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            cs_n_q  <= cs_n_d;
            idle_q  <= idle_d;
            tmo_q   <= tmo_d;
`ifdef READ_TIMEOUT_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    assign reconfig_data    = data_q;
    assign reconfig_data_en = en_q;
    assign bpi_idle         = idle_q;
    assign bpi_addr         = addr_q;
    assign bpi_ce_n         = cs_n_q;
    assign bpi_oe_n         = cs_n_q;
    assign bpi_we_n         = 1'b1;
    assign bpi_adv_n        = 1'b0;
    assign read_timeout     = tmo_q;

endmodule

// File: tb/tb_bpi_flash_reader.sv
// Directed bench for bpi_flash_reader; flash model returns the low 16 address bits.
module tb_bpi_flash_reader;

    localparam int PER = 8;  // T_ACC + 2 at defaults

    logic        clk = 1'b0;
    logic        rst;
    logic        start, cont, endr;
    logic [15:0] din, data;
    logic        en, idle, ce_n, oe_n, we_n, adv_n, tmo;
    logic [23:0] addr;

    logic        start2, cont2, end2;
    logic [15:0] din2, data2;
    logic        en2, idle2, ce_n2, oe_n2, we_n2, adv_n2, tmo2;
    logic [23:0] addr2;

    int n_cmp = 0, n_err = 0, cyc = 0, nw = 0;

    always #5 clk = ~clk;

    assign din  = addr[15:0];
    assign din2 = addr2[15:0];

    bpi_flash_reader #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .reconfig_read_start(start), .reconfig_read_continue(cont), .reconfig_read_end(endr),
        .bpi_data_in(din), .reconfig_data(data), .reconfig_data_en(en), .bpi_idle(idle),
        .bpi_addr(addr), .bpi_ce_n(ce_n), .bpi_oe_n(oe_n), .bpi_we_n(we_n),
        .bpi_adv_n(adv_n), .read_timeout(tmo)
    );

    bpi_flash_reader #(.START_ADDR(24'hFFFFFE), .BURST_LEN(4)) dut2 (
        .clk(clk), .rst(rst),
        .reconfig_read_start(start2), .reconfig_read_continue(cont2), .reconfig_read_end(end2),
        .bpi_data_in(din2), .reconfig_data(data2), .reconfig_data_en(en2), .bpi_idle(idle2),
        .bpi_addr(addr2), .bpi_ce_n(ce_n2), .bpi_oe_n(oe_n2), .bpi_we_n(we_n2),
        .bpi_adv_n(adv_n2), .read_timeout(tmo2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; request inputs are single-cycle pulses
    task automatic step();
        @(posedge clk);
        #1;
        start = 0; cont = 0; endr = 0;
        start2 = 0; cont2 = 0; end2 = 0;
        cyc++;
    endtask

    task automatic collect(input string tag, input int ncyc, input int d0);
        repeat (ncyc) begin
            step();
            if (en) begin
                chk({tag, " en cycle"}, cyc, PER * (nw + 1));
                chk({tag, " data"}, {16'h0, data}, d0 + nw);
                nw++;
            end
        end
    endtask

    initial begin
        logic [15:0] exp2 [4];
        int np, bad;
        exp2 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rst = 0; start = 0; cont = 0; endr = 0; start2 = 0; cont2 = 0; end2 = 0;
        step(); step();
        chk("rst addr", addr, 24'h0);
        chk("rst ce_n", ce_n, 1);
        chk("rst oe_n", oe_n, 1);
        chk("rst we_n", we_n, 1);
        chk("rst adv_n", adv_n, 0);
        chk("rst data", data, 0);
        chk("rst en", en, 0);
        chk("rst idle", idle, 1);
        chk("rst timeout", tmo, 0);
        chk("rst addr2", addr2, 24'hFFFFFE);
        rst = 1;
        step();

        // first burst from address 0
        start = 1; cyc = 0; nw = 0;
        collect("t1", 64, 0);
        chk("t1 words", nw, 8);
        step();
        chk("t1 hold addr", addr, 24'h8);
        chk("t1 hold ce_n", ce_n, 1);
        chk("t1 hold oe_n", oe_n, 1);
        chk("t1 hold idle", idle, 0);

        // continue 5 cycles into HOLD, then close
        repeat (5) step();
        cont = 1; cyc = 0; nw = 0;
        collect("t2", 64, 8);
        chk("t2 words", nw, 8);
        step();
        chk("t2 hold addr", addr, 24'h10);
        endr = 1; cyc = 0;
        step();
        chk("t2 rec ce_n", ce_n, 1);
        chk("t2 idle c1", idle, 0);
        step();
        chk("t2 idle c2", idle, 0);
        step();
        chk("t2 idle c3", idle, 1);
        chk("t2 idle addr", addr, 24'h0);

        // abort in WAIT of word 3
        start = 1; cyc = 0; nw = 0;
        collect("t3", 28, 0);
        chk("t3 words before end", nw, 3);
        endr = 1;
        step();
        chk("t3 ce_n after end", ce_n, 1);
        step();
        chk("t3 idle c30", idle, 0);
        step();
        chk("t3 idle c31", idle, 1);
        collect("t3 tail", 9, 0);
        chk("t3 words total", nw, 3);

        // restart from 0; a start mid-burst must not disturb the sequence
        start = 1; cyc = 0; nw = 0;
        collect("t4", 20, 0);
        start = 1;
        collect("t4", 44, 0);
        chk("t4 words", nw, 8);
        step();
        cont = 1; endr = 1; cyc = 0; nw = 0;
        step();
        chk("t4 ce_n after end", ce_n, 1);
        collect("t4 post", 11, 0);
        chk("t4 no data after end", nw, 0);
        chk("t4 idle", idle, 1);

        // address wrap at the top of the space
        start2 = 1; cyc = 0; nw = 0;
        step();
        chk("t5 setup addr", addr2, 24'hFFFFFE);
        repeat (31) begin
            step();
            if (en2) begin
                if (nw < 4) begin
                    chk("t5 en cycle", cyc, PER * (nw + 1));
                    chk("t5 data", {16'h0, data2}, {16'h0, exp2[nw]});
                end
                nw++;
            end
        end
        chk("t5 words", nw, 4);
        step();
        chk("t5 hold addr", addr2, 24'h000002);
        end2 = 1;
        step();

        // HOLD dwell behaviour
        start = 1; cyc = 0; nw = 0;
        collect("t6", 64, 0);
        step();
`ifdef READ_TIMEOUT_EN
        np = 0;
        repeat (120) begin
            step();
            if (tmo) begin
                np++;
                chk("t6 timeout cycle", cyc, 165);
            end
            if (cyc == 167) chk("t6 idle after timeout", idle, 1);
        end
        chk("t6 timeout pulses", np, 1);
`else
        bad = 0;
        repeat (10000) begin
            step();
            if (idle || tmo || ce_n !== 1'b1) bad++;
        end
        chk("t6 hold persists", bad, 0);
        endr = 1;
        repeat (3) step();
        chk("t6 idle after end", idle, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
